// File: rtl/phase_ramp.sv
// Per-sample phase generator for carrier-frequency-offset correction.
// Tags each sample of a packet with an accumulated phase and emits {phase, q, i}.
module phase_ramp #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 c_valid,
  output logic                 c_ready,
  input  logic [2*WIDTH-1:0]   c_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [2*WIDTH-1:0]   s_data,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [4*WIDTH-1:0]   m_data,
  output logic                 m_last
);

  localparam int PW = 2 * WIDTH;
  localparam int DW = 4 * WIDTH;
  localparam int BW = DW + 1;

  logic [PW-1:0] freq_pend_q, freq_pend_d;
  logic [PW-1:0] freq_act_q,  freq_act_d;
  logic [PW-1:0] acc_q,       acc_d;
  logic          sop_q,       sop_d;
  logic          main_valid_q, main_valid_d;
  logic [BW-1:0] main_word_q,  main_word_d;
  logic          skid_valid_q, skid_valid_d;
  logic [BW-1:0] skid_word_q,  skid_word_d;

  logic          accept;
  logic [PW-1:0] phase;
  logic [BW-1:0] in_word;

  assign c_ready = ~reset;
  assign s_ready = ~skid_valid_q & ~reset;
  assign m_valid = main_valid_q;
  assign m_last  = main_word_q[DW];
  assign m_data  = main_word_q[DW-1:0];

  // Phase accumulation: the frequency word is latched only at a packet start
  always_comb begin
    accept      = s_valid & s_ready;
    freq_pend_d = freq_pend_q;
    freq_act_d  = freq_act_q;
    acc_d       = acc_q;
    sop_d       = sop_q;

    if (c_valid && c_ready) begin
      freq_pend_d = c_data;
    end else begin
      freq_pend_d = freq_pend_q;
    end

    if (sop_q) begin
      phase = {PW{1'b0}};
    end else begin
      phase = acc_q;
    end

    if (accept) begin
      if (sop_q) begin
        freq_act_d = freq_pend_q;
        acc_d      = freq_pend_q;
      end else begin
        acc_d      = acc_q + freq_act_q;
      end
      sop_d = s_last;
    end else begin
      sop_d = sop_q;
    end

    in_word = {s_last, phase, s_data};
  end

  // Two-entry output buffer: main feeds the port, skid absorbs one beat of stall
  always_comb begin
    main_valid_d = main_valid_q;
    main_word_d  = main_word_q;
    skid_valid_d = skid_valid_q;
    skid_word_d  = skid_word_q;

    if (!main_valid_q || m_ready) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_word_d  = skid_word_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_word_d  = in_word;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_word_d  = in_word;
    end else begin
      skid_valid_d = skid_valid_q;
    end
  end

  // State registers; reset discards any held samples and restarts at a packet boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      freq_pend_q  <= {PW{1'b0}};
      freq_act_q   <= {PW{1'b0}};
      acc_q        <= {PW{1'b0}};
      sop_q        <= 1'b1;
      main_valid_q <= 1'b0;
      main_word_q  <= {BW{1'b0}};
      skid_valid_q <= 1'b0;
      skid_word_q  <= {BW{1'b0}};
    end else begin
      freq_pend_q  <= freq_pend_d;
      freq_act_q   <= freq_act_d;
      acc_q        <= acc_d;
      sop_q        <= sop_d;
      main_valid_q <= main_valid_d;
      main_word_q  <= main_word_d;
      skid_valid_q <= skid_valid_d;
      skid_word_q  <= skid_word_d;
    end
  end

endmodule

// File: tb/tb_phase_ramp.sv
// Directed and randomised-handshake bench for phase_ramp; outputs are
// captured at the falling edge and compared against hand-computed phases.
module tb_phase_ramp;

  localparam int WIDTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        c_valid = 1'b0;
  logic        c_ready;
  logic [31:0] c_data = 32'h0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = 32'h0;
  logic        s_last = 1'b0;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic        m_last;

  logic        rand_mr = 1'b0;
  logic        mr_fixed = 1'b1;
  logic        mr_rnd = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  logic [64:0] mq[$];

  assign m_ready = rand_mr ? mr_rnd : mr_fixed;

  phase_ramp #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .c_valid(c_valid), .c_ready(c_ready), .c_data(c_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  // output handshakes completing at the next rising edge
  always @(negedge clk) begin
    if (!reset && m_valid && m_ready) mq.push_back({m_last, m_data});
  end

  always begin
    @(posedge clk);
    #1;
    mr_rnd = 1'($urandom_range(0, 1));
  end

  task automatic do_cfg(input logic [31:0] w);
    c_valid = 1'b1;
    c_data  = w;
    @(posedge clk); #1;
    c_valid = 1'b0;
  endtask

  task automatic send_sample(input logic [15:0] i, input logic [15:0] q, input logic last,
                             input logic cfg_en, input logic [31:0] cfg_word);
    int n = 0;
    logic took = 1'b0;
    s_valid = 1'b1; s_data = {q, i}; s_last = last;
    c_valid = cfg_en; c_data = cfg_word;
    do begin
      @(negedge clk);
      took = s_ready;
      @(posedge clk); #1;
      c_valid = 1'b0;
      n++;
    end while (!took && n < 60);
    s_valid = 1'b0;
    if (!took) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: sample i=%h not accepted in %0d cycles", i, n);
    end
  endtask

  task automatic collect(input int n);
    int cyc = 0;
    while (mq.size() < n && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    vectors++;
    if (mq.size() != n) begin
      miscompares++;
      $display("FAIL collect: got %0d outputs, required %0d", mq.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({m_valid, m_last, m_data, s_ready, c_ready} !== 67'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: m_valid=%b m_last=%b m_data=%h s_ready=%b c_ready=%b, required all 0",
               m_valid, m_last, m_data, s_ready, c_ready);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (s_ready !== 1'b1 || c_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release: s_ready=%b c_ready=%b, required 1 1", s_ready, c_ready);
    end
    mq.delete();
  endtask

  task automatic test_ramp();
    logic [64:0] exp;
    mr_fixed = 1'b1;
    do_cfg(32'h0100_0000);
    for (int j = 0; j < 4; j++) begin
      send_sample(16'd100, 16'hFF9C, 1'(j == 3), 1'b0, 32'h0);
      exp = {1'(j == 3), 32'(j * 32'h0100_0000), 16'hFF9C, 16'd100};
      vectors++;
      if (m_valid !== 1'b1 || {m_last, m_data} !== exp) begin
        miscompares++;
        $display("FAIL ramp[%0d]: m_valid=%b got %h, required %h", j, m_valid, {m_last, m_data}, exp);
      end
    end
    repeat (2) @(posedge clk); #1;
    mq.delete();
  endtask

  task automatic test_wrap();
    logic [31:0] ph[6];
    logic [64:0] got, exp;
    ph[0] = 32'h0; ph[1] = 32'h4000_0000; ph[2] = 32'h8000_0000;
    ph[3] = 32'hC000_0000; ph[4] = 32'h0; ph[5] = 32'h4000_0000;
    do_cfg(32'h4000_0000);
    for (int j = 0; j < 6; j++) send_sample(16'(j + 1), 16'(j + 50), 1'(j == 5), 1'b0, 32'h0);
    collect(6);
    for (int j = 0; j < 6; j++) begin
      got = (j < mq.size()) ? mq[j] : 65'bx;
      exp = {1'(j == 5), ph[j], 16'(j + 50), 16'(j + 1)};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL wrap[%0d]: got %h, required %h", j, got, exp);
      end
    end
    mq.delete();
  endtask

  task automatic test_boundary();
    logic [31:0] ph[13];
    logic [64:0] got, exp;
    int          lastpos[4];
    ph[0] = 32'h0; ph[1] = 32'h10000; ph[2] = 32'h20000; ph[3] = 32'h30000;
    ph[4] = 32'h0; ph[5] = 32'h20000; ph[6] = 32'h40000;
    ph[7] = 32'h0; ph[8] = 32'h20000; ph[9] = 32'h40000;
    ph[10] = 32'h0; ph[11] = 32'h30000; ph[12] = 32'h60000;
    lastpos[0] = 3; lastpos[1] = 6; lastpos[2] = 9; lastpos[3] = 12;
    do_cfg(32'h0001_0000);
    send_sample(16'd0, 16'd0, 1'b0, 1'b0, 32'h0);
    send_sample(16'd1, 16'd0, 1'b0, 1'b0, 32'h0);
    do_cfg(32'h0002_0000);
    send_sample(16'd2, 16'd0, 1'b0, 1'b0, 32'h0);
    send_sample(16'd3, 16'd0, 1'b1, 1'b0, 32'h0);
    for (int j = 4; j < 7; j++) send_sample(16'(j), 16'd0, 1'(j == 6), 1'b0, 32'h0);
    send_sample(16'd7, 16'd0, 1'b0, 1'b1, 32'h0003_0000);
    for (int j = 8; j < 13; j++) send_sample(16'(j), 16'd0, 1'(j == 9 || j == 12), 1'b0, 32'h0);
    collect(13);
    for (int j = 0; j < 13; j++) begin
      got = (j < mq.size()) ? mq[j] : 65'bx;
      exp = {1'(j == lastpos[0] || j == lastpos[1] || j == lastpos[2] || j == lastpos[3]),
             ph[j], 16'd0, 16'(j)};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL boundary[%0d]: got %h, required %h", j, got, exp);
      end
    end
    mq.delete();
  endtask

  task automatic test_negative();
    logic [31:0] ph[3];
    logic [64:0] got, exp;
    ph[0] = 32'h0; ph[1] = 32'hFFFF_0000; ph[2] = 32'hFFFE_0000;
    do_cfg(32'hFFFF_0000);
    for (int j = 0; j < 3; j++) send_sample(16'h8000, 16'h7FFF, 1'(j == 2), 1'b0, 32'h0);
    collect(3);
    for (int j = 0; j < 3; j++) begin
      got = (j < mq.size()) ? mq[j] : 65'bx;
      exp = {1'(j == 2), ph[j], 16'h7FFF, 16'h8000};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL negative[%0d]: got %h, required %h", j, got, exp);
      end
    end
    mq.delete();
  endtask

  task automatic test_back_to_back();
    int idx = 0, cyc = 0, acc_low = 0, sr_low = 0;
    logic [64:0] got, exp;
    mr_fixed = 1'b1;
    do_cfg(32'h0000_0100);
    while (idx < 10 && cyc < 100) begin
      mr_fixed = !(cyc >= 4 && cyc < 9);
      s_valid = 1'b1; s_data = {16'(200 + idx), 16'(idx)}; s_last = 1'(idx == 9);
      @(negedge clk);
      if (!mr_fixed && s_ready) acc_low++;
      if (cyc >= 5 && cyc < 9 && !s_ready) sr_low++;
      if (s_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 1'b0; mr_fixed = 1'b1;
    vectors++;
    if (acc_low != 1) begin
      miscompares++;
      $display("FAIL stall_accepts: got %0d accepts while stalled, required 1", acc_low);
    end
    vectors++;
    if (sr_low != 4) begin
      miscompares++;
      $display("FAIL stall_s_ready: s_ready low in %0d of cycles 5..8, required 4", sr_low);
    end
    collect(10);
    for (int j = 0; j < 10; j++) begin
      got = (j < mq.size()) ? mq[j] : 65'bx;
      exp = {1'(j == 9), 32'(j * 32'h100), 16'(200 + j), 16'(j)};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL stall_seq[%0d]: got %h, required %h", j, got, exp);
      end
    end
    mq.delete();
  endtask

  task automatic test_random();
    logic [64:0] expq[$];
    logic [64:0] got;
    logic [31:0] freq, ph;
    logic [15:0] ri, rq;
    int remaining = 1000, len;
    freq = $urandom;
    do_cfg(freq);
    rand_mr = 1'b1;
    while (remaining > 0) begin
      len = $urandom_range(1, 8);
      if (len > remaining) len = remaining;
      if ($urandom_range(0, 3) == 0) begin
        freq = $urandom;
        do_cfg(freq);
      end
      ph = 32'h0;
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 1) == 1) begin
          @(posedge clk); #1;
        end
        ri = 16'($urandom); rq = 16'($urandom);
        expq.push_back({1'(j == len - 1), ph, rq, ri});
        send_sample(ri, rq, 1'(j == len - 1), 1'b0, 32'h0);
        ph = ph + freq;
      end
      remaining -= len;
    end
    rand_mr = 1'b0;
    mr_fixed = 1'b1;
    collect(1000);
    for (int j = 0; j < 1000; j++) begin
      got = (j < mq.size()) ? mq[j] : 65'bx;
      vectors++;
      if (got !== expq[j]) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h, required %h", j, got, expq[j]);
      end
    end
    mq.delete();
  endtask

  task automatic test_reset_mid();
    logic [64:0] got, exp;
    mr_fixed = 1'b1;
    do_cfg(32'h0000_1000);
    send_sample(16'd1, 16'd1, 1'b0, 1'b0, 32'h0);
    send_sample(16'd2, 16'd2, 1'b0, 1'b0, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (m_valid !== 1'b0 || s_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: m_valid=%b s_ready=%b, required 0 0", m_valid, s_ready);
    end
    reset = 1'b0;
    mq.delete();
    for (int j = 0; j < 3; j++) send_sample(16'(10 + j), 16'(20 + j), 1'(j == 2), 1'b0, 32'h0);
    collect(3);
    for (int j = 0; j < 3; j++) begin
      got = (j < mq.size()) ? mq[j] : 65'bx;
      exp = {1'(j == 2), 32'h0, 16'(20 + j), 16'(10 + j)};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL reset_mid_seq[%0d]: got %h, required %h", j, got, exp);
      end
    end
    mq.delete();
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_wrap();
    test_boundary();
    test_negative();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/phase_ramp.md
# phase_ramp

Per-sample phase generator for carrier-frequency-offset correction. It accepts a packetised complex baseband stream plus a frequency word. It emits each sample tagged with an accumulated phase, packed as {phase, q, i} to feed the CORDIC rotation stage directly. Phase restarts at zero on every packet. A new frequency word takes effect only at a packet boundary, so a packet is never rotated with two slopes.

## Interface
- WIDTH, 16, sample component width; phase and frequency words are 2*WIDTH bits
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- c_valid  in  1  frequency word valid
- c_ready  out  1  frequency word ready
- c_data  in  2*WIDTH  signed frequency word, phase increment per sample (full turn = 2^(2*WIDTH))
- s_valid  in  1  input sample valid
- s_ready  out  1  input sample ready
- s_data  in  2*WIDTH  {q, i}, signed WIDTH each, i in LSBs
- s_last  in  1  last sample of packet
- m_valid  out  1  output valid
- m_ready  in  1  output ready
- m_data  out  4*WIDTH  {phase[2*WIDTH-1:0], q, i}, i in LSBs
- m_last  out  1  s_last delayed with its sample

## Operation
- Phase convention: unsigned modular 2*WIDTH-bit; 0 = 0 rad, 1<<(2*WIDTH-1) = pi. Addition wraps silently; no saturation.
- Registers: freq_pend, freq_act, acc (2*WIDTH each); sop flag (next accepted sample starts a packet).
- Config: c_ready = !reset. On c_valid && c_ready, freq_pend <= c_data. Later beats overwrite earlier ones; only the last beat before a packet start matters.
- On sample accept (s_valid && s_ready):
  - If sop: emitted phase = 0; freq_act <= freq_pend (value before this edge); acc <= freq_pend.
  - Else: emitted phase = acc; acc <= acc + freq_act.
  - sop <= s_last.
- A config beat and a packet's first sample in the same cycle: the new word is NOT used for that packet. It applies from the next packet.
- i, q and last pass through unmodified.
- Phase advances only on accepted samples. Stalls and bubbles do not advance it.
- Output is a 2-entry skid buffer (main + skid register). s_ready is registered: s_ready = !skid_full.
  - Accept with main empty, or main draining this cycle: data goes to main.
  - Accept while main is held (m_valid && !m_ready): data goes to skid, and s_ready deasserts next cycle.
  - When main drains, skid moves to main and s_ready reasserts next cycle.
- Mid-packet reset: all state cleared and held data discarded. The next accepted sample is treated as a packet start with phase 0 and freq 0 unless reconfigured.

## Timing
- Reset values: m_valid=0, m_last=0, m_data=0, s_ready=0 and c_ready=0 while reset is high. s_ready=1 and c_ready=1 the first cycle after reset. freq_pend=freq_act=acc=0, sop=1.
- Latency: sample accepted at edge k appears on m_data with m_valid=1 after edge k (one register). Throughput is one sample per cycle with m_ready high.
- m_data and m_last are stable while m_valid && !m_ready. m_valid does not drop without a handshake.
- At most one sample is accepted after m_ready falls; at most 2 samples are in flight.
- Upstream must hold s_data stable while s_valid && !s_ready; behaviour is undefined otherwise.

## Test plan
- Ramp: config 0x01000000, then a 4-sample packet with i=100, q=-100, last on sample 4 -> phases 0x00000000, 0x01000000, 0x02000000, 0x03000000; i/q unchanged; m_last only on sample 4; 1-cycle latency.
- Wrap: config 0x40000000, 6-sample packet -> phases 0, 0x40000000, 0x80000000, 0xC0000000, 0x00000000, 0x40000000.
- Boundary update:
  - freq 0x00010000, then 0x00020000 written mid-packet -> current packet keeps step 0x10000.
  - Next packet runs 0, 0x20000, 0x40000.
  - Config in the same cycle as a first sample -> that packet uses the old word.
- Backpressure:
  - m_ready low for 5 cycles mid-stream -> exactly one extra sample accepted; s_ready low from the following cycle; no loss or duplication; phase sequence contiguous.
  - Random m_ready/s_valid (50%) over 1000 samples -> scoreboard match.
- Negative freq: config 0xFFFF0000 -> phases 0, 0xFFFF0000, 0xFFFE0000.
- Reset mid-packet: assert reset after sample 2 of a 5-sample packet -> m_valid=0 next cycle. First post-reset sample gets phase 0 and subsequent samples phase 0 (freq cleared to 0).
